// File: rtl/mesh_pe_route_if.sv
// ============================================================================
// Module      : mesh_pe_route_if
// Description : Handshake and neighbour-link bundle of one mesh sort/route PE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mesh_pe_route_if #(
  parameter int W = 21
);
  logic         i_load;
  logic [W-1:0] i_load_word;
  logic         i_start;
  logic [W-1:0] i_PE_l;
  logic [W-1:0] i_PE_r;
  logic [W-1:0] i_PE_u;
  logic [W-1:0] i_PE_d;
  logic [W-1:0] o_PE;
  logic [2:0]   o_phase;
  logic         o_done;
  logic         o_collision;

  // The PE side.
  modport slave (
    input  i_load, i_load_word, i_start,
    input  i_PE_l, i_PE_r, i_PE_u, i_PE_d,
    output o_PE, o_phase, o_done, o_collision
  );

  // The array / controller side.
  modport master (
    output i_load, i_load_word, i_start,
    output i_PE_l, i_PE_r, i_PE_u, i_PE_d,
    input  o_PE, o_phase, o_done, o_collision
  );
endinterface

`default_nettype wire

// File: rtl/mesh_pe_route.sv
// ============================================================================
// Module      : mesh_pe_route
// Description : Mesh PE that runs a ROM-driven compare-exchange sort and then
//               row and column ring alignment, so words land at their dest PE.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mesh_pe_route #(
  parameter int                       SQRT_N      = 4,
  parameter int                       ADDR_WIDTH  = 2,
  parameter int                       DATA_WIDTH  = 16,
  parameter int                       MY_ROW      = 0,
  parameter int                       MY_COL      = 0,
  parameter int                       SORT_CYCLES = 16,
  // Sort program, entry k at bits [4k+3:4k].
  parameter logic [4*SORT_CYCLES-1:0] ROM_INIT    = '0,
  parameter int                       CNT_WIDTH   = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  mesh_pe_route_if.slave     bus
);

  localparam int W  = 1 + 2*ADDR_WIDTH + DATA_WIDTH;
  localparam int KW = 2*ADDR_WIDTH + 1;

  localparam logic [ADDR_WIDTH-1:0] C_MY_ROW     = ADDR_WIDTH'(MY_ROW);
  localparam logic [ADDR_WIDTH-1:0] C_MY_COL     = ADDR_WIDTH'(MY_COL);
  localparam logic [CNT_WIDTH-1:0]  C_SORT_LAST  = CNT_WIDTH'(SORT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0]  C_ALIGN_LAST = CNT_WIDTH'(SQRT_N - 1);
  localparam logic [CNT_WIDTH-1:0]  C_CNT_ONE    = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SORT = 3'd1,
    S_ROW  = 3'd2,
    S_COL  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [CNT_WIDTH-1:0]  r_cnt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic [W-1:0]          r_comm;
  logic [W-1:0]          w_comm_nxt;
  logic [W-1:0]          r_cap;
  logic [W-1:0]          w_cap_nxt;
  logic                  r_coll;
  logic                  w_coll_nxt;

  logic [3:0]            w_op;
  logic [W-1:0]          w_nbr;
  logic [W-1:0]          w_sort_word;
  logic [W-1:0]          w_ring;
  logic                  w_match;

  // Invalid words carry a set MSB in the key so they sort after every valid word.
  function automatic logic [KW-1:0] f_key(input logic [W-1:0] w);
    return {~w[W-1], w[W-2 -: 2*ADDR_WIDTH]};
  endfunction

  assign w_op = ROM_INIT[{r_cnt, 2'b00} +: 4];

  always_comb begin
    w_nbr = bus.i_PE_l;
    case (w_op[1:0])
      2'b01:   w_nbr = bus.i_PE_r;
      2'b10:   w_nbr = bus.i_PE_u;
      2'b11:   w_nbr = bus.i_PE_d;
      default: w_nbr = bus.i_PE_l;
    endcase

    // Strict compares so a tie keeps the held word.
    w_sort_word = r_comm;
    case (w_op[3:2])
      2'b11:   w_sort_word = w_nbr;
      2'b01:   if (f_key(w_nbr) > f_key(r_comm)) w_sort_word = w_nbr;
      2'b10:   if (f_key(w_nbr) < f_key(r_comm)) w_sort_word = w_nbr;
      default: w_sort_word = r_comm;
    endcase
  end

  assign w_ring  = (r_state == S_ROW) ? bus.i_PE_l : bus.i_PE_u;
  assign w_match = r_comm[W-1] &&
                   ((r_state == S_ROW) ? (r_comm[DATA_WIDTH +: ADDR_WIDTH] == C_MY_COL)
                                       : (r_comm[DATA_WIDTH+ADDR_WIDTH +: ADDR_WIDTH] == C_MY_ROW));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_comm_nxt  = r_comm;
    w_cap_nxt   = r_cap;
    w_coll_nxt  = r_coll;

    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.i_load) w_comm_nxt = bus.i_load_word;
        if (bus.i_start) begin
          w_state_nxt = S_SORT;
          w_cnt_nxt   = '0;
          w_coll_nxt  = 1'b0;
        end
      end

      S_SORT: begin
        w_comm_nxt = w_sort_word;
        w_cnt_nxt  = r_cnt + C_CNT_ONE;
        if (r_cnt == C_SORT_LAST) begin
          w_state_nxt = S_ROW;
          w_cnt_nxt   = '0;
        end
      end

      S_ROW, S_COL: begin
        // The valid bit of the capture register doubles as its full flag.
        if (w_match) begin
          if (r_cap[W-1]) w_coll_nxt = 1'b1;
          else            w_cap_nxt  = r_comm;
        end
        w_comm_nxt = w_ring;
        w_cnt_nxt  = r_cnt + C_CNT_ONE;
        if (r_cnt == C_ALIGN_LAST) begin
          w_comm_nxt  = w_cap_nxt;
          w_cap_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = (r_state == S_ROW) ? S_COL : S_DONE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_comm  <= '0;
      r_cap   <= '0;
      r_coll  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_comm  <= w_comm_nxt;
      r_cap   <= w_cap_nxt;
      r_coll  <= w_coll_nxt;
    end
  end

  assign bus.o_PE        = r_comm;
  assign bus.o_phase     = r_state;
  assign bus.o_done      = (r_state == S_DONE);
  assign bus.o_collision = r_coll;

endmodule

`default_nettype wire

// File: tb/tb_mesh_pe_route.sv
// ============================================================================
// Module      : tb_mesh_pe_route
// Description : Two PEs (2x2 PE(0,0) with a hold-only ROM, 4x4 PE(0,1) with a
//               compare/copy ROM) checked against a list-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mesh_pe_route;

  localparam int          W     = 21;
  localparam int          SC    = 4;
  localparam int          NCYC  = SC + 2*4;
  localparam logic [15:0] ROM_A = 16'h2130;
  localparam logic [15:0] ROM_B = 16'h7C95;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         ld_a = 1'b0, st_a = 1'b0, ld_b = 1'b0, st_b = 1'b0;
  logic [W-1:0] wa = '0, wb = '0;
  logic [W-1:0] nbl = '0, nbr = '0, nbu = '0, nbd = '0;

  logic [W-1:0] nl [NCYC];
  logic [W-1:0] nr [NCYC];
  logic [W-1:0] nu [NCYC];
  logic [W-1:0] nd [NCYC];

  int n_checks = 0;
  int n_fail   = 0;

  mesh_pe_route_if #(.W(W)) ifa ();
  mesh_pe_route_if #(.W(W)) ifb ();

  assign ifa.i_load = ld_a;  assign ifa.i_load_word = wa;  assign ifa.i_start = st_a;
  assign ifb.i_load = ld_b;  assign ifb.i_load_word = wb;  assign ifb.i_start = st_b;
  assign ifa.i_PE_l = nbl;   assign ifa.i_PE_r = nbr;  assign ifa.i_PE_u = nbu;  assign ifa.i_PE_d = nbd;
  assign ifb.i_PE_l = nbl;   assign ifb.i_PE_r = nbr;  assign ifb.i_PE_u = nbu;  assign ifb.i_PE_d = nbd;

  mesh_pe_route #(
    .SQRT_N(2), .ADDR_WIDTH(2), .DATA_WIDTH(16), .MY_ROW(0), .MY_COL(0),
    .SORT_CYCLES(SC), .ROM_INIT(ROM_A), .CNT_WIDTH(8)
  ) u_a (.clk(clk), .rst(rst), .bus(ifa));

  mesh_pe_route #(
    .SQRT_N(4), .ADDR_WIDTH(2), .DATA_WIDTH(16), .MY_ROW(0), .MY_COL(1),
    .SORT_CYCLES(SC), .ROM_INIT(ROM_B), .CNT_WIDTH(8)
  ) u_b (.clk(clk), .rst(rst), .bus(ifb));

  function automatic logic [W-1:0] mk(input bit v, input int r, input int c, input int p);
    logic [W-1:0] w;
    w = {v, 2'(r), 2'(c), 16'(p)};
    return w;
  endfunction

  function automatic logic [W-1:0] rand_word();
    return mk($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 65535));
  endfunction

  function automatic int key(input logic [W-1:0] w);
    return (w[20] ? 0 : 16) + 4 * int'(w[19:18]) + int'(w[17:16]);
  endfunction

  function automatic int exp_phase(input int n, input int sq);
    if (n < SC)        return 1;
    if (n < SC + sq)   return 2;
    if (n < SC + 2*sq) return 3;
    return 4;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Scan the words the PE holds during one alignment phase; first match wins.
  task automatic align(input logic [W-1:0] w0, input int first, input int sq, input bit by_col,
                       input int me, output logic [W-1:0] res, output bit coll);
    logic [W-1:0] seen[$];
    int hits;
    seen.push_back(w0);
    for (int i = 0; i < sq - 1; i++) seen.push_back(by_col ? nl[first+i] : nu[first+i]);
    res  = '0;
    hits = 0;
    foreach (seen[i]) begin
      int field;
      field = by_col ? int'(seen[i][17:16]) : int'(seen[i][19:18]);
      if (seen[i][20] && field == me) begin
        if (hits == 0) res = seen[i];
        hits++;
      end
    end
    coll = (hits > 1);
  endtask

  task automatic model(input logic [15:0] rom, input int sq, input int my_row, input int my_col,
                       input logic [W-1:0] sw, output logic [W-1:0] steps[SC],
                       output logic [W-1:0] fin, output bit coll);
    logic [W-1:0] w, n, r1, r2;
    bit c1, c2;
    int op;
    w = sw;
    for (int k = 0; k < SC; k++) begin
      op = int'((rom >> (4*k)) & 16'hF);
      case (op % 4)
        0: n = nl[k];
        1: n = nr[k];
        2: n = nu[k];
        default: n = nd[k];
      endcase
      if (op / 4 == 3) w = n;
      else if (op / 4 == 1 && key(n) > key(w)) w = n;
      else if (op / 4 == 2 && key(n) < key(w)) w = n;
      steps[k] = w;
    end
    align(w,  SC,      sq, 1'b1, my_col, r1, c1);
    align(r1, SC + sq, sq, 1'b0, my_row, r2, c2);
    fin  = r2;
    coll = c1 | c2;
  endtask

  task automatic clear_nbrs();
    for (int j = 0; j < NCYC; j++) begin
      nl[j] = '0; nr[j] = '0; nu[j] = '0; nd[j] = '0;
    end
  endtask

  task automatic rand_nbrs();
    for (int j = 0; j < NCYC; j++) begin
      nl[j] = rand_word(); nr[j] = rand_word(); nu[j] = rand_word(); nd[j] = rand_word();
    end
  endtask

  task automatic run_txn(input string name, input logic [W-1:0] sw_a, input logic [W-1:0] sw_b,
                         input bit combo, input bit ign);
    logic [W-1:0] sa[SC];
    logic [W-1:0] sb[SC];
    logic [W-1:0] fa, fb;
    bit ca, cb;
    int done_a, done_b;
    model(ROM_A, 2, 0, 0, sw_a, sa, fa, ca);
    model(ROM_B, 4, 0, 1, sw_b, sb, fb, cb);

    @(negedge clk);
    ld_a = 1'b1; ld_b = 1'b1; wa = sw_a; wb = sw_b; st_a = combo; st_b = combo;
    @(posedge clk);
    if (!combo) begin
      @(negedge clk);
      ld_a = 1'b0; ld_b = 1'b0; st_a = 1'b1; st_b = 1'b1;
      @(posedge clk);
    end
    #1;
    chk({name, "/a_coll_clr"}, 32'(ifa.o_collision), 32'd0);
    chk({name, "/b_coll_clr"}, 32'(ifb.o_collision), 32'd0);

    done_a = -1;
    done_b = -1;
    for (int j = 0; j < NCYC; j++) begin
      @(negedge clk);
      ld_a = 1'b0; ld_b = 1'b0; st_a = 1'b0; st_b = 1'b0;
      nbl = nl[j]; nbr = nr[j]; nbu = nu[j]; nbd = nd[j];
      if (ign && j == SC + 2) begin ld_a = 1'b1; st_a = 1'b1; wa = rand_word(); end
      if (ign && j == SC + 5) begin ld_b = 1'b1; st_b = 1'b1; wb = rand_word(); end
      @(posedge clk);
      #1;
      chk($sformatf("%s/a_phase@%0d", name, j), 32'(ifa.o_phase), 32'(exp_phase(j + 1, 2)));
      chk($sformatf("%s/b_phase@%0d", name, j), 32'(ifb.o_phase), 32'(exp_phase(j + 1, 4)));
      chk($sformatf("%s/a_done@%0d", name, j), 32'(ifa.o_done), 32'(exp_phase(j + 1, 2) == 4));
      chk($sformatf("%s/b_done@%0d", name, j), 32'(ifb.o_done), 32'(exp_phase(j + 1, 4) == 4));
      if (j < SC) begin
        chk($sformatf("%s/a_sort@%0d", name, j), 32'(ifa.o_PE), 32'(sa[j]));
        chk($sformatf("%s/b_sort@%0d", name, j), 32'(ifb.o_PE), 32'(sb[j]));
      end
      if (done_a < 0 && ifa.o_done) done_a = j + 2;
      if (done_b < 0 && ifb.o_done) done_b = j + 2;
    end
    nbl = '0; nbr = '0; nbu = '0; nbd = '0;

    chk({name, "/a_latency"}, 32'(done_a), 32'(SC + 2*2 + 1));
    chk({name, "/b_latency"}, 32'(done_b), 32'(SC + 2*4 + 1));
    chk({name, "/a_final"},   32'(ifa.o_PE), 32'(fa));
    chk({name, "/b_final"},   32'(ifb.o_PE), 32'(fb));
    chk({name, "/a_coll"},    32'(ifa.o_collision), 32'(ca));
    chk({name, "/b_coll"},    32'(ifb.o_collision), 32'(cb));
  endtask

  initial begin
    logic [W-1:0] w0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst/a_phase", 32'(ifa.o_phase), 32'd0);
    chk("rst/b_phase", 32'(ifb.o_phase), 32'd0);
    chk("rst/a_pe",    32'(ifa.o_PE),    32'd0);
    chk("rst/b_done",  32'(ifb.o_done),  32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Latency: hold-only ROM, word already home at PE(0,0).
    clear_nbrs();
    w0 = mk(1'b1, 0, 0, 16'h1234);
    run_txn("latency", w0, w0, 1'b0, 1'b0);
    chk("latency/a_home", 32'(ifa.o_PE), 32'(w0));

    // Sort ops on PE B: max with right (key 3 vs 5), then min with right (key 2).
    clear_nbrs();
    nr[0] = mk(1'b1, 1, 1, 16'h0005);
    nr[1] = mk(1'b1, 0, 2, 16'h0002);
    run_txn("sortop", mk(1'b1, 1, 1, 16'h7777), mk(1'b1, 0, 3, 16'h0003), 1'b1, 1'b0);

    // Row capture on PE(0,1) at ROW_ALIGN cycle 1.
    clear_nbrs();
    nl[SC + 1] = mk(1'b1, 0, 1, 16'hBEEF);
    run_txn("rowcap", rand_word(), '0, 1'b0, 1'b0);
    chk("rowcap/b_word", 32'(ifb.o_PE), 32'(mk(1'b1, 0, 1, 16'hBEEF)));

    // Collision: two column-1 words in one ROW_ALIGN; first one kept.
    clear_nbrs();
    nl[SC]     = mk(1'b1, 0, 1, 16'hAAAA);
    nl[SC + 1] = mk(1'b1, 2, 1, 16'hBBBB);
    run_txn("collision", rand_word(), '0, 1'b0, 1'b0);
    chk("collision/b_flag", 32'(ifb.o_collision), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("collision/b_sticky", 32'(ifb.o_collision), 32'd1);

    // Handshakes pulsed during COL_ALIGN are ignored; this start clears the flag.
    rand_nbrs();
    run_txn("ignored", rand_word(), rand_word(), 1'b0, 1'b1);

    // Reset mid-SORT.
    @(negedge clk);
    ld_a = 1'b1; ld_b = 1'b1; wa = rand_word(); wb = mk(1'b1, 3, 3, 16'h5A5A); st_a = 1'b1; st_b = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld_a = 1'b0; ld_b = 1'b0; st_a = 1'b0; st_b = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("midrst/a_phase", 32'(ifa.o_phase),     32'd0);
    chk("midrst/b_phase", 32'(ifb.o_phase),     32'd0);
    chk("midrst/b_pe",    32'(ifb.o_PE),        32'd0);
    chk("midrst/b_done",  32'(ifb.o_done),      32'd0);
    chk("midrst/b_coll",  32'(ifb.o_collision), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int t = 0; t < 25; t++) begin
      rand_nbrs();
      run_txn($sformatf("rand%0d", t), rand_word(), rand_word(),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
